// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin port arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Requester index to one-hot strobe.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_port_arbiter_if.sv
// Request/response bundle between the arbiter and the requesters/resource side.
interface mux_port_arbiter_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             res_done;
  logic [SEL_W-1:0] mux_sel;
  logic [SEL_W-1:0] demux_sel;
  logic [N_REQ-1:0] grant;
  logic             res_start;
  logic [N_REQ-1:0] resp_valid;
  logic             resp_err;
  logic             busy;

  // Requesters and resource side.
  modport master (
    output req, res_done,
    input  mux_sel, demux_sel, grant, res_start, resp_valid, resp_err, busy
  );

  // Arbiter side.
  modport slave (
    input  req, res_done,
    output mux_sel, demux_sel, grant, res_start, resp_valid, resp_err, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request after the last owner.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down so the nearest candidate wins.
  always_comb begin
    any  = |req;
    idx  = last;
    cand = last;
    for (int i = N_REQ; i > 0; i--) begin
      cand = last + SEL_W'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_port_arbiter.sv
// Round-robin sequencer sharing one resource among four requesters, with timeout abort.
module mux_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  mux_port_arbiter_if.slave  arb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic [SEL_W-1:0] demux_sel_q, demux_sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             res_start_q, res_start_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic             busy_q, busy_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  rr_pick u_pick (
    .req  (arb.req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    mux_sel_d    = mux_sel_q;
    demux_sel_d  = demux_sel_q;
    grant_d      = grant_q;
    res_start_d  = 1'b0;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = ISSUE;
          last_d      = pick_idx;
          mux_sel_d   = pick_idx;
          demux_sel_d = pick_idx;
          grant_d     = onehot(pick_idx);
          res_start_d = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the last timeout cycle still counts as success.
        if (arb.res_done) begin
          state_d      = RESP;
          resp_valid_d = onehot(demux_sel_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d      = RESP;
          resp_valid_d = onehot(demux_sel_q);
          resp_err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_q       <= SEL_W'(N_REQ - 1);
      cnt_q        <= '0;
      mux_sel_q    <= '0;
      demux_sel_q  <= '0;
      grant_q      <= '0;
      res_start_q  <= 1'b0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      mux_sel_q    <= mux_sel_d;
      demux_sel_q  <= demux_sel_d;
      grant_q      <= grant_d;
      res_start_q  <= res_start_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign arb.mux_sel    = mux_sel_q;
  assign arb.demux_sel  = demux_sel_q;
  assign arb.grant      = grant_q;
  assign arb.res_start  = res_start_q;
  assign arb.resp_valid = resp_valid_q;
  assign arb.resp_err   = resp_err_q;
  assign arb.busy       = busy_q;

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Directed and randomized transactions against a transaction-level round-robin model.
module tb_mux_port_arbiter;
  import arb_pkg::*;

  localparam int unsigned T = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_last      = 3;
  int   starts_seen = 0;

  always #5 clk = ~clk;

  mux_port_arbiter_if bus ();

  mux_port_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .arb     (bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester found at last+1, last+2, ... mod 4.
  function automatic int model_pick(input logic [3:0] r, input int last);
    for (int off = 1; off <= 4; off++) begin
      int c;
      c = (last + off) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mux"},   8'(bus.mux_sel),    8'h0);
    chk({tag, "_demux"}, 8'(bus.demux_sel),  8'h0);
    chk({tag, "_grant"}, 8'(bus.grant),      8'h0);
    chk({tag, "_start"}, 8'(bus.res_start),  8'h0);
    chk({tag, "_rv"},    8'(bus.resp_valid), 8'h0);
    chk({tag, "_err"},   8'(bus.resp_err),   8'h0);
    chk({tag, "_busy"},  8'(bus.busy),       8'h0);
  endtask

  // Entered during an IDLE cycle with bus.req already set to a nonzero value.
  // done_after: res_done driven this many cycles after the res_start cycle (<0: never).
  task automatic do_txn(input int done_after, input bit use_mid, input logic [3:0] mid_req,
                        input bit drop);
    int owner;
    int resp_cyc;
    bit err;
    logic [3:0] oh;
    owner = model_pick(bus.req, m_last);
    if (owner < 0) begin
      chk("txn_req_nonzero", 8'(bus.req), 8'h1);
      return;
    end
    oh = onehot(SEL_W'(owner));
    if (done_after >= 1 && done_after <= int'(T)) begin
      resp_cyc = done_after + 2;
      err      = 1'b0;
    end else begin
      resp_cyc = int'(T) + 2;
      err      = 1'b1;
    end

    step();
    if (bus.res_start) starts_seen++;
    chk("issue_grant", 8'(bus.grant),     8'(oh));
    chk("issue_mux",   8'(bus.mux_sel),   8'(owner));
    chk("issue_start", 8'(bus.res_start), 8'h1);
    chk("issue_busy",  8'(bus.busy),      8'h1);
    chk("issue_rv",    8'(bus.resp_valid), 8'h0);
    m_last = owner;
    if (done_after == 0) bus.res_done = 1'b1;

    for (int c = 2; c <= resp_cyc; c++) begin
      step();
      bus.res_done = 1'b0;
      if (c == 1 + done_after) bus.res_done = 1'b1;
      if (c == 2 && use_mid) bus.req = mid_req;
      if (bus.res_start) starts_seen++;
      if (c < resp_cyc) begin
        chk("wait_rv",    8'(bus.resp_valid), 8'h0);
        chk("wait_start", 8'(bus.res_start),  8'h0);
        chk("wait_grant", 8'(bus.grant),      8'(oh));
        chk("wait_busy",  8'(bus.busy),       8'h1);
      end else begin
        chk("resp_rv",    8'(bus.resp_valid), 8'(oh));
        chk("resp_err",   8'(bus.resp_err),   8'(err));
        chk("resp_demux", 8'(bus.demux_sel),  8'(owner));
        chk("resp_busy",  8'(bus.busy),       8'h1);
        if (drop) bus.req[owner] = 1'b0;
      end
    end

    step();
    bus.res_done = 1'b0;
    chk("idle_grant", 8'(bus.grant),      8'h0);
    chk("idle_rv",    8'(bus.resp_valid), 8'h0);
    chk("idle_err",   8'(bus.resp_err),   8'h0);
    chk("idle_busy",  8'(bus.busy),       8'h0);
    chk("idle_mux",   8'(bus.mux_sel),    8'(owner));
    chk("idle_demux", 8'(bus.demux_sel),  8'(owner));
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.req      = 4'b0000;
    bus.res_done = 1'b0;
    #2;
    chk_all_zero("reset");
    step();
    step();
    reset_n = 1'b1;

    // Four simultaneous requesters, each dropping after its response: order 0,1,2,3.
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      do_txn(2 + i, 1'b0, 4'b0000, 1'b1);
      chk("all4_order", 8'(bus.mux_sel), 8'(i));
    end
    chk("all4_starts", 8'(starts_seen), 8'd4);

    // Single request, done three cycles after start.
    bus.req = 4'b0001;
    do_txn(3, 1'b0, 4'b0000, 1'b1);
    chk("single_owner", 8'(bus.mux_sel), 8'd0);

    // Fairness: requester 2 holds, requester 1 joins during the wait.
    bus.req = 4'b0100;
    do_txn(2, 1'b1, 4'b0110, 1'b0);
    chk("fair_first", 8'(bus.mux_sel), 8'd2);
    do_txn(1, 1'b0, 4'b0000, 1'b1);
    chk("fair_second", 8'(bus.mux_sel), 8'd1);
    do_txn(4, 1'b0, 4'b0000, 1'b1);
    chk("fair_third", 8'(bus.mux_sel), 8'd2);

    // Timeout with no done, then done on the final timeout cycle.
    bus.req = 4'b0001;
    do_txn(-1, 1'b0, 4'b0000, 1'b0);
    do_txn(int'(T), 1'b0, 4'b0000, 1'b1);

    // Reset in the middle of WAIT.
    bus.req = 4'b0010;
    step();
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    m_last  = 3;
    bus.req = 4'b1000;
    step();
    chk("rst_hold_rv", 8'(bus.resp_valid), 8'h0);
    step();
    chk("rst_hold_rv", 8'(bus.resp_valid), 8'h0);
    reset_n = 1'b1;
    do_txn(2, 1'b0, 4'b0000, 1'b1);
    chk("post_rst_owner", 8'(bus.mux_sel), 8'd3);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      bus.req = 4'($urandom_range(0, 15));
      if (bus.req == 4'b0000) begin
        step();
        chk("rand_idle_grant", 8'(bus.grant), 8'h0);
        chk("rand_idle_busy",  8'(bus.busy),  8'h0);
        chk("rand_idle_mux",   8'(bus.mux_sel), 8'(m_last));
      end else begin
        int da;
        da = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T + 1));
        do_txn(da, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
